// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage interlock.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One in-flight write: which architectural register will be written.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } inflight_entry_t;

    localparam inflight_entry_t ENTRY_EMPTY = '{valid: 1'b0, rd: '0};

    // One-hot register mask; x0 is hardwired zero so it never appears as busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask    = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/inflight_tracker.sv
// Shift register of destination registers for instructions between ID/EX and writeback.
// Latency: push visible in busy_mask/matches the cycle after the issuing edge.
// Backpressure: none; shifts every edge, stall or not (stalls insert empty entries).
module inflight_tracker
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_valid,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [REG_ADDR_W-1:0] rs0_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  rs0_match,
    output logic                  rs1_match
);

    inflight_entry_t      entry [DEPTH];
    logic [DEPTH-1:0]     active;
    logic                 push_real;

    // x0 writes are discarded at the door so they can never create a hazard.
    assign push_real = push_valid && (push_rd != '0);

    // Pipeline advance: youngest enters at slot 0, oldest retires out of the last slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= ENTRY_EMPTY;
            end
        end else begin
            if (push_real) begin
                entry[0] <= '{valid: 1'b1, rd: push_rd};
            end else begin
                entry[0] <= ENTRY_EMPTY;
            end
            for (int i = 1; i < DEPTH; i++) begin
                entry[i] <= entry[i-1];
            end
        end
    end

    // With a write-before-read register file, the entry writing back this cycle is already readable.
    always_comb begin
        active = '0;
        for (int i = 0; i < DEPTH; i++) begin
            active[i] = entry[i].valid && !(WB_BYPASS && (i == DEPTH - 1));
        end
    end

    // Pending-write mask over all entries that can still hazard a reader.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (active[i]) begin
                busy_mask = busy_mask | reg_onehot(entry[i].rd);
            end
        end
        busy_mask[0] = 1'b0;
    end

    // A source matches when its register has a pending write; x0 bit is always clear.
    assign rs0_match = (rs0_addr != '0) && busy_mask[rs0_addr];
    assign rs1_match = (rs1_addr != '0) && busy_mask[rs1_addr];

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage interlock: stalls fetch/decode and bubbles ID/EX on RAW hazards, honours flush.
// Latency: issue/stall_if/bubble_ex are combinational from ID inputs and tracker state.
// Backpressure: stall_if holds PC and IF/ID until all sources clear; flush overrides hazard.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs0_addr,
    input  logic                  id_rs0_en,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_en,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_rd_en,
    input  logic                  flush,
    output logic                  issue,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [CNT_W-1:0]      stall_count
);

    logic rs0_match;
    logic rs1_match;
    logic hazard;

    // The instruction's own rd is only pushed after it issues, so it never hazards itself.
    inflight_tracker #(
        .DEPTH     (DEPTH),
        .WB_BYPASS (WB_BYPASS)
    ) u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (issue && id_rd_en),
        .push_rd    (id_rd_addr),
        .rs0_addr   (id_rs0_addr),
        .rs1_addr   (id_rs1_addr),
        .busy_mask  (busy_mask),
        .rs0_match  (rs0_match),
        .rs1_match  (rs1_match)
    );

    assign hazard = (id_rs0_en && rs0_match) || (id_rs1_en && rs1_match);

    // Flush kills the ID instruction outright, so it neither issues nor holds the front end.
    always_comb begin
        issue     = id_valid && !flush && !hazard;
        stall_if  = id_valid && !flush && hazard;
        bubble_ex = !issue;
    end

    // Performance counter: one per stall cycle, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_if && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs0;
        logic       rs0_en;
        logic [4:0] rs1;
        logic       rs1_en;
        logic [4:0] rd;
        logic       rd_en;
        logic       flush;
    } id_t;

    id_t in_a, in_b, in_c;

    logic        issue_a, stall_a, bub_a;
    logic [31:0] busy_a, cnt_a;
    logic        issue_b, stall_b, bub_b;
    logic [31:0] busy_b, cnt_b;
    logic        issue_c, stall_c, bub_c;
    logic [31:0] busy_c;
    logic [3:0]  cnt_c;

    // Default configuration: DEPTH=3, write-before-read register file.
    hazard_stall_ctrl #(.DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .id_valid(in_a.valid),
        .id_rs0_addr(in_a.rs0), .id_rs0_en(in_a.rs0_en),
        .id_rs1_addr(in_a.rs1), .id_rs1_en(in_a.rs1_en),
        .id_rd_addr(in_a.rd), .id_rd_en(in_a.rd_en), .flush(in_a.flush),
        .issue(issue_a), .stall_if(stall_a), .bubble_ex(bub_a),
        .busy_mask(busy_a), .stall_count(cnt_a));

    // No writeback bypass: the final stage is still a hazard.
    hazard_stall_ctrl #(.DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_valid(in_b.valid),
        .id_rs0_addr(in_b.rs0), .id_rs0_en(in_b.rs0_en),
        .id_rs1_addr(in_b.rs1), .id_rs1_en(in_b.rs1_en),
        .id_rd_addr(in_b.rd), .id_rd_en(in_b.rd_en), .flush(in_b.flush),
        .issue(issue_b), .stall_if(stall_b), .bubble_ex(bub_b),
        .busy_mask(busy_b), .stall_count(cnt_b));

    // Narrow counter for saturation.
    hazard_stall_ctrl #(.DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .id_valid(in_c.valid),
        .id_rs0_addr(in_c.rs0), .id_rs0_en(in_c.rs0_en),
        .id_rs1_addr(in_c.rs1), .id_rs1_en(in_c.rs1_en),
        .id_rd_addr(in_c.rd), .id_rd_en(in_c.rd_en), .flush(in_c.flush),
        .issue(issue_c), .stall_if(stall_c), .bubble_ex(bub_c),
        .busy_mask(busy_c), .stall_count(cnt_c));

    typedef struct {
        int          dut;
        logic        issue;
        logic        stall;
        logic        bubble;
        logic [31:0] busy;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    function automatic id_t mk(input logic [4:0] rs0, input logic rs0_en,
                               input logic [4:0] rs1, input logic rs1_en,
                               input logic [4:0] rd, input logic rd_en, input logic fl);
        id_t v;
        v.valid  = 1'b1;
        v.rs0    = rs0;
        v.rs0_en = rs0_en;
        v.rs1    = rs1;
        v.rs1_en = rs1_en;
        v.rd     = rd;
        v.rd_en  = rd_en;
        v.flush  = fl;
        return v;
    endfunction

    // Drive one cycle on one DUT (others idle), queue its expectation, check mid-cycle.
    task automatic cyc(input int d, input id_t v, input logic ei, input logic es,
                       input logic [31:0] em, input logic [31:0] ec, input string tag);
        exp_t        e;
        logic        oi, os, ob;
        logic [31:0] om, oc;
        in_a = (d == 0) ? v : '0;
        in_b = (d == 1) ? v : '0;
        in_c = (d == 2) ? v : '0;
        e.dut = d; e.issue = ei; e.stall = es; e.bubble = !ei;
        e.busy = em; e.cnt = ec; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        case (e.dut)
            0:       begin oi = issue_a; os = stall_a; ob = bub_a; om = busy_a; oc = cnt_a; end
            1:       begin oi = issue_b; os = stall_b; ob = bub_b; om = busy_b; oc = cnt_b; end
            default: begin oi = issue_c; os = stall_c; ob = bub_c; om = busy_c; oc = {28'd0, cnt_c}; end
        endcase
        chk(e.tag, "issue",       {31'd0, oi}, {31'd0, e.issue});
        chk(e.tag, "stall_if",    {31'd0, os}, {31'd0, e.stall});
        chk(e.tag, "bubble_ex",   {31'd0, ob}, {31'd0, e.bubble});
        chk(e.tag, "busy_mask",   om, e.busy);
        chk(e.tag, "stall_count", oc, e.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        id_t idle, p5, c6, x0p, x0c, ind9, ind10, indn, cfl, own, p6, c2, csat;
        int  stalls;
        idle  = '0;
        p5    = mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x1,imm
        c6    = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
        x0p   = mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x1,imm
        x0c   = mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);   // reads x0,x0
        ind9  = mk(5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        ind10 = mk(5'd7, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0);
        indn  = mk(5'd7, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        cfl   = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1);   // consumer with flush
        own   = mk(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x5,x5
        p6    = mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        c2    = mk(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b0, 1'b0);   // reads x5 and x6
        csat  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x5,x1

        reset_n = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state on every instance
        cyc(0, idle, 1'b0, 1'b0, 32'h0, 32'd0, "rst_a");
        cyc(1, idle, 1'b0, 1'b0, 32'h0, 32'd0, "rst_b");
        cyc(2, idle, 1'b0, 1'b0, 32'h0, 32'd0, "rst_c");

        // Basic RAW with writeback bypass: 2 stall cycles
        cyc(0, p5,   1'b1, 1'b0, 32'h0,  32'd0, "byp_prod");
        cyc(0, c6,   1'b0, 1'b1, 32'h20, 32'd0, "byp_st1");
        cyc(0, c6,   1'b0, 1'b1, 32'h20, 32'd1, "byp_st2");
        cyc(0, c6,   1'b1, 1'b0, 32'h0,  32'd2, "byp_iss");
        cyc(0, idle, 1'b0, 1'b0, 32'h40, 32'd2, "byp_after");

        // x0 never recorded nor matched
        cyc(0, x0p,  1'b1, 1'b0, 32'h40, 32'd2, "x0_prod");
        cyc(0, x0c,  1'b1, 1'b0, 32'h0,  32'd2, "x0_cons");

        // Independent sources issue back to back
        cyc(0, p5,    1'b1, 1'b0, 32'h0,   32'd2, "ind_prod");
        cyc(0, ind9,  1'b1, 1'b0, 32'h20,  32'd2, "ind_1");
        cyc(0, ind10, 1'b1, 1'b0, 32'h220, 32'd2, "ind_2");
        cyc(0, indn,  1'b1, 1'b0, 32'h600, 32'd2, "ind_3");
        cyc(0, idle,  1'b0, 1'b0, 32'h400, 32'd2, "ind_drain1");
        cyc(0, idle,  1'b0, 1'b0, 32'h0,   32'd2, "ind_drain2");

        // Flush during a stall: priority over hazard, count frozen, entry retires on time
        cyc(0, p5,   1'b1, 1'b0, 32'h0,  32'd2, "fl_prod");
        cyc(0, c6,   1'b0, 1'b1, 32'h20, 32'd2, "fl_stall");
        cyc(0, cfl,  1'b0, 1'b0, 32'h20, 32'd3, "fl_flush");
        cyc(0, c6,   1'b1, 1'b0, 32'h0,  32'd3, "fl_reiss");
        cyc(0, idle, 1'b0, 1'b0, 32'h40, 32'd3, "fl_d1");
        cyc(0, idle, 1'b0, 1'b0, 32'h40, 32'd3, "fl_d2");
        cyc(0, idle, 1'b0, 1'b0, 32'h0,  32'd3, "fl_d3");

        // Own rd as source is not a hazard
        cyc(0, own,  1'b1, 1'b0, 32'h0,  32'd3, "own");
        cyc(0, idle, 1'b0, 1'b0, 32'h20, 32'd3, "own_d1");
        cyc(0, idle, 1'b0, 1'b0, 32'h20, 32'd3, "own_d2");
        cyc(0, idle, 1'b0, 1'b0, 32'h0,  32'd3, "own_d3");

        // Two sources on different pending entries: stall until the later clears
        cyc(0, p5, 1'b1, 1'b0, 32'h0,  32'd3, "two_p5");
        cyc(0, p6, 1'b1, 1'b0, 32'h20, 32'd3, "two_p6");
        cyc(0, c2, 1'b0, 1'b1, 32'h60, 32'd3, "two_st1");
        cyc(0, c2, 1'b0, 1'b1, 32'h40, 32'd4, "two_st2");
        cyc(0, c2, 1'b1, 1'b0, 32'h0,  32'd5, "two_iss");

        // No bypass: 3 stall cycles, busy[5] over three cycles
        cyc(1, p5,   1'b1, 1'b0, 32'h0,  32'd0, "nb_prod");
        cyc(1, c6,   1'b0, 1'b1, 32'h20, 32'd0, "nb_st1");
        cyc(1, c6,   1'b0, 1'b1, 32'h20, 32'd1, "nb_st2");
        cyc(1, c6,   1'b0, 1'b1, 32'h20, 32'd2, "nb_st3");
        cyc(1, c6,   1'b1, 1'b0, 32'h0,  32'd3, "nb_iss");
        cyc(1, idle, 1'b0, 1'b0, 32'h40, 32'd3, "nb_after");

        // Asynchronous reset in the middle of a stall
        cyc(0, p5, 1'b1, 1'b0, 32'h0,  32'd5, "mr_prod");
        cyc(0, c6, 1'b0, 1'b1, 32'h20, 32'd5, "mr_stall");
        reset_n = 1'b0;
        cyc(0, c6, 1'b1, 1'b0, 32'h0,  32'd0, "mr_inrst");
        reset_n = 1'b1;
        cyc(0, c6,   1'b1, 1'b0, 32'h0,  32'd0, "mr_release");
        cyc(0, idle, 1'b0, 1'b0, 32'h40, 32'd0, "mr_after");

        // Saturation of a 4-bit counter under a self-dependent stream
        stalls = 0;
        for (int i = 0; i < 33; i++) begin
            logic ph0;
            ph0 = ((i % 3) == 0);
            cyc(2, csat, ph0, !ph0, ph0 ? 32'h0 : 32'h20,
                (stalls > 15) ? 32'd15 : 32'(stalls), $sformatf("sat%0d", i));
            if (!ph0) stalls++;
        end
        cyc(2, idle, 1'b0, 1'b0, 32'h0, 32'd15, "sat_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
